// File: rtl/sched_cmd_pkg.sv
// sched_cmd_pkg: scheduler command codes, PIM op encodings, FSM states and command decode
package sched_cmd_pkg;
    localparam logic [4:0] C_LW = 5'b01001, C_LHU = 5'b01010, C_LBU = 5'b01011;
    localparam logic [4:0] C_SW = 5'b00001, C_SH = 5'b00010, C_SB = 5'b00011;
    localparam logic [4:0] C_ADD = 5'b10000, C_MUL = 5'b10010, C_RELU = 5'b11000;
    localparam logic [4:0] C_MAXPOOL = 5'b11001, C_MOVE = 5'b11011;
    localparam logic [2:0] OP_ADD = 3'd0, OP_MUL = 3'd1, OP_RELU = 3'd2, OP_MAXPOOL = 3'd3, OP_MOVE = 3'd4;

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, PIM_START, PIM_WAIT, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef struct packed {
        logic       mem;
        logic       we;
        logic       pim;
        size_t      sz;
        logic [2:0] op;
    } dec_t;

    function automatic dec_t decode(input logic [4:0] c);
        dec_t d;
        d = '0;
        case (c)
            C_LW:      begin d.mem = 1'b1; d.sz = SZ_W; end
            C_LHU:     begin d.mem = 1'b1; d.sz = SZ_H; end
            C_LBU:     begin d.mem = 1'b1; d.sz = SZ_B; end
            C_SW:      begin d.mem = 1'b1; d.we = 1'b1; d.sz = SZ_W; end
            C_SH:      begin d.mem = 1'b1; d.we = 1'b1; d.sz = SZ_H; end
            C_SB:      begin d.mem = 1'b1; d.we = 1'b1; d.sz = SZ_B; end
            C_ADD:     begin d.pim = 1'b1; d.op = OP_ADD; end
            C_MUL:     begin d.pim = 1'b1; d.op = OP_MUL; end
            C_RELU:    begin d.pim = 1'b1; d.op = OP_RELU; end
            C_MAXPOOL: begin d.pim = 1'b1; d.op = OP_MAXPOOL; end
            C_MOVE:    begin d.pim = 1'b1; d.op = OP_MOVE; end
            default:   ;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] a);
        return (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
    endfunction
endpackage

// File: rtl/sched_lane_align.sv
// sched_lane_align: byte-enable/store-data lane shaping and load-lane extract with zero-extend
module sched_lane_align
    import sched_cmd_pkg::*;
(
    input  size_t       sz,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);
    always_comb begin
        be = sz == SZ_W ? 4'b1111 : sz == SZ_H ? 4'b0011 << lane : 4'b0001 << lane;
        wdata_lane = sz == SZ_W ? wdata : sz == SZ_H ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        rdata_ext = sz == SZ_W ? rdata :
                    sz == SZ_H ? {16'h0, rdata[{lane[1], 4'b0000} +: 16]} :
                                 {24'h0, rdata[{lane, 3'b000} +: 8]};
    end
endmodule

// File: rtl/sched_cmd_issuer.sv
// sched_cmd_issuer: issues one scheduler command to bank memory or PIM engine and returns its response
module sched_cmd_issuer
    import sched_cmd_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int PIM_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_code,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              pim_start,
    output logic [2:0]        pim_op,
    output logic [ADDR_W-1:0] pim_addr,
    input  logic              pim_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);
    localparam int TW = $clog2(PIM_TIMEOUT);

    state_t        state;
    dec_t          dec;
    size_t         sz_q, sz_sel;
    logic [1:0]    lane_q, lane_sel;
    logic [TW-1:0] timer;
    logic [3:0]    be;
    logic [31:0]   wdata_lane, rdata_ext;

    assign dec = decode(cmd_code);
    // shape from the live command while idle, extract from the latched one afterwards
    assign sz_sel = state == IDLE ? dec.sz : sz_q;
    assign lane_sel = state == IDLE ? cmd_addr[1:0] : lane_q;

    sched_lane_align u_align (
        .sz(sz_sel),
        .lane(lane_sel),
        .wdata(cmd_wdata),
        .rdata(mem_rdata),
        .be(be),
        .wdata_lane(wdata_lane),
        .rdata_ext(rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            pim_start <= 1'b0;
            pim_op <= '0;
            pim_addr <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            timer <= '0;
            sz_q <= SZ_B;
            lane_q <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    sz_q <= dec.sz;
                    lane_q <= cmd_addr[1:0];
                    rsp_data <= '0;
                    if (!(dec.mem || dec.pim) || (dec.mem && misaligned(dec.sz, cmd_addr[1:0]))) begin
                        state <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err <= 1'b1;
                    end else if (dec.mem) begin
                        state <= MEM_REQ;
                        mem_req <= 1'b1;
                        mem_we <= dec.we;
                        mem_be <= be;
                        mem_addr <= {cmd_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= dec.we ? wdata_lane : '0;
                    end else begin
                        state <= PIM_START;
                        pim_start <= 1'b1;
                        pim_op <= dec.op;
                        pim_addr <= cmd_addr;
                    end
                end
                MEM_REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state <= mem_we ? RESP : MEM_WAIT;
                    rsp_valid <= mem_we;
                    rsp_err <= 1'b0;
                end
                MEM_WAIT: if (mem_rvalid) begin
                    state <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err <= 1'b0;
                    rsp_data <= rdata_ext;
                end
                PIM_START: begin
                    pim_start <= 1'b0;
                    timer <= '0;
                    state <= PIM_WAIT;
                end
                PIM_WAIT: if (pim_done || timer == TW'(PIM_TIMEOUT - 1)) begin
                    state <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err <= !pim_done;
                end else begin
                    timer <= timer + 1'b1;
                end
                RESP: if (rsp_ready) begin
                    state <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err <= 1'b0;
                    rsp_data <= '0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sched_cmd_issuer.sv
// tb_sched_cmd_issuer: directed table plus randomized commands checked against a behavioural model
module tb_sched_cmd_issuer;
    localparam int TO = 8;

    logic        clk, rst, cmd_valid, cmd_ready;
    logic [4:0]  cmd_code;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        pim_start, pim_done;
    logic [2:0]  pim_op;
    logic [31:0] pim_addr;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_fail = 0;

    sched_cmd_issuer #(.ADDR_W(32), .PIM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pim_start(pim_start), .pim_op(pim_op), .pim_addr(pim_addr), .pim_done(pim_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // g: gnt cycles after req, r: rvalid cycles after gnt, k: done cycles after start (<=0 none/at start),
    // rdy: rsp cycles before rsp_ready; e_kind 0=error 1=store 2=load 3=pim
    typedef struct {
        logic [4:0]  code;
        logic [31:0] addr, wdata, rdata;
        int          g, r, k, rdy;
        bit          noise;
        bit          e_err;
        logic [31:0] e_data;
        int          e_kind;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [2:0]  e_op;
        int          e_lat;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        int nb, lane;
        bit ld, st, pim;
        longint m;
        nb = 0; ld = 0; st = 0; pim = 0;
        lane = int'(v.addr % 4);
        v.e_op = 0; v.e_be = 0; v.e_wdata = 0; v.e_data = 0;
        case (v.code)
            5'b01001: begin ld = 1; nb = 4; end
            5'b01010: begin ld = 1; nb = 2; end
            5'b01011: begin ld = 1; nb = 1; end
            5'b00001: begin st = 1; nb = 4; end
            5'b00010: begin st = 1; nb = 2; end
            5'b00011: begin st = 1; nb = 1; end
            5'b10000: begin pim = 1; v.e_op = 0; end
            5'b10010: begin pim = 1; v.e_op = 1; end
            5'b11000: begin pim = 1; v.e_op = 2; end
            5'b11001: begin pim = 1; v.e_op = 3; end
            5'b11011: begin pim = 1; v.e_op = 4; end
            default: ;
        endcase
        if (!(ld || st || pim) || (nb > 0 && lane % nb != 0)) begin
            v.e_err = 1; v.e_kind = 0; v.e_lat = 0; v.e_op = 0;
        end else if (pim) begin
            v.e_kind = 3;
            v.e_err = !(v.k >= 1 && v.k <= TO);
            v.e_lat = v.e_err ? TO + 1 : v.k + 1;
        end else begin
            v.e_err = 0;
            v.e_kind = st ? 1 : 2;
            m = (64'd1 << (8 * nb)) - 1;
            v.e_be = 4'(((1 << nb) - 1) << lane);
            v.e_wdata = st ? 32'((longint'(v.wdata) & m) * (nb == 4 ? 1 : nb == 2 ? 32'h10001 : 32'h1010101)) : 0;
            v.e_data = ld ? 32'((longint'(v.rdata) >> (8 * lane)) & m) : 0;
            v.e_lat = st ? v.g + 1 : v.g + v.r + 1;
        end
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        int gc = -1, sc = -1, nv = 0, lat = -1, nreq = 0, nst = 0;
        bit got = 0, stable = 1, fin = 0;
        logic [31:0] rd = 0, ma = 0, mw = 0, pa = 0;
        logic re = 0, we = 0;
        logic [3:0] be = 0;
        logic [2:0] op = 0;
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1; cmd_code = v.code; cmd_addr = v.addr; cmd_wdata = v.wdata;
        step();
        cmd_valid = 0; cmd_code = 5'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        for (int c = 0; c < 40 && !fin; c++) begin
            mem_gnt = 0; mem_rvalid = 0; pim_done = 0; rsp_ready = 0; mem_rdata = $urandom;
            if (mem_req) begin
                if (nreq == 0) begin be = mem_be; we = mem_we; ma = mem_addr; mw = mem_wdata; end
                nreq++;
                mem_rvalid = v.noise;
                if (c == v.g) begin mem_gnt = 1; gc = c; end
            end
            if (gc >= 0 && c == gc + v.r) begin mem_rvalid = 1; mem_rdata = v.rdata; end
            if (v.noise && nst == 0) pim_done = 1;
            if (v.noise && sc >= 0) mem_rvalid = 1;
            if (pim_start) begin
                nst++;
                if (sc < 0) begin sc = c; op = pim_op; pa = pim_addr; end
                if (v.k == 0) pim_done = 1;
            end
            if (sc >= 0 && v.k > 0 && c == sc + v.k) pim_done = 1;
            if (rsp_valid) begin
                if (got && (rsp_data !== rd || rsp_err !== re)) stable = 0;
                if (cmd_ready !== 1'b0) stable = 0;
                if (!got) begin got = 1; lat = c; rd = rsp_data; re = rsp_err; end
                if (nv == v.rdy) begin rsp_ready = 1; fin = 1; end
                nv++;
            end
            step();
        end
        rsp_ready = 0; mem_gnt = 0; mem_rvalid = 0; pim_done = 0;
        chk({tag, "_rsp_seen"}, 64'(got), 64'(1));
        chk({tag, "_rsp_err"}, 64'(re), 64'(v.e_err));
        chk({tag, "_rsp_data"}, 64'(rd), 64'(v.e_data));
        chk({tag, "_latency"}, 64'(lat), 64'(v.e_lat));
        chk({tag, "_rsp_stable"}, 64'(stable), 64'(1));
        chk({tag, "_release"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
        if (v.e_kind == 1 || v.e_kind == 2) begin
            chk({tag, "_req_cycles"}, 64'(nreq), 64'(v.g + 1));
            chk({tag, "_mem_be"}, 64'(be), 64'(v.e_be));
            chk({tag, "_mem_we"}, 64'(we), 64'(v.e_kind == 1));
            chk({tag, "_mem_addr"}, 64'(ma), 64'(v.addr & ~32'h3));
            if (v.e_kind == 1) chk({tag, "_mem_wdata"}, 64'(mw), 64'(v.e_wdata));
        end else begin
            chk({tag, "_no_req"}, 64'(nreq), 64'(0));
        end
        chk({tag, "_starts"}, 64'(nst), 64'(v.e_kind == 3));
        if (v.e_kind == 3) begin
            chk({tag, "_pim_op"}, 64'(op), 64'(v.e_op));
            chk({tag, "_pim_addr"}, 64'(pa), 64'(v.addr));
        end
    endtask

    vec_t tbl[19];
    logic [4:0] pool[16] = '{5'b01001, 5'b01010, 5'b01011, 5'b00001, 5'b00010, 5'b00011,
                             5'b10000, 5'b10010, 5'b11000, 5'b11001, 5'b11011,
                             5'b00000, 5'b10001, 5'b11111, 5'b01000, 5'b00100};

    initial begin
        rst = 1; cmd_valid = 0; cmd_code = 0; cmd_addr = 0; cmd_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; pim_done = 0; rsp_ready = 0;
        // code, addr, wdata, rdata, g, r, k, rdy, noise, err, data, kind, be, wdata, op, lat
        tbl[0]  = '{5'b00001, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, -1, 0, 0, 0, 32'h0, 1, 4'hF, 32'hDEADBEEF, 3'd0, 1};
        tbl[1]  = '{5'b00011, 32'h103, 32'h5A, 32'h0, 0, 1, -1, 0, 0, 0, 32'h0, 1, 4'h8, 32'h5A5A5A5A, 3'd0, 1};
        tbl[2]  = '{5'b01011, 32'h103, 32'h0, 32'hAB000000, 0, 1, -1, 0, 0, 0, 32'hAB, 2, 4'h8, 32'h0, 3'd0, 2};
        tbl[3]  = '{5'b01010, 32'h101, 32'h0, 32'h0, 0, 1, -1, 0, 0, 1, 32'h0, 0, 4'h0, 32'h0, 3'd0, 0};
        tbl[4]  = '{5'b00000, 32'h100, 32'h0, 32'h0, 0, 1, -1, 0, 0, 1, 32'h0, 0, 4'h0, 32'h0, 3'd0, 0};
        tbl[5]  = '{5'b10001, 32'h100, 32'h0, 32'h0, 0, 1, -1, 0, 0, 1, 32'h0, 0, 4'h0, 32'h0, 3'd0, 0};
        tbl[6]  = '{5'b10010, 32'h40, 32'h0, 32'h0, 0, 1, 5, 0, 0, 0, 32'h0, 3, 4'h0, 32'h0, 3'd1, 6};
        tbl[7]  = '{5'b11000, 32'h80, 32'h0, 32'h0, 0, 1, -1, 0, 0, 1, 32'h0, 3, 4'h0, 32'h0, 3'd2, 9};
        tbl[8]  = '{5'b11000, 32'h80, 32'h0, 32'h0, 0, 1, 8, 0, 0, 0, 32'h0, 3, 4'h0, 32'h0, 3'd2, 9};
        tbl[9]  = '{5'b00010, 32'h102, 32'h1234ABCD, 32'h0, 1, 1, -1, 10, 0, 0, 32'h0, 1, 4'hC, 32'hABCDABCD, 3'd0, 2};
        tbl[10] = '{5'b01010, 32'h102, 32'h0, 32'hBEEF1234, 0, 3, -1, 0, 0, 0, 32'hBEEF, 2, 4'hC, 32'h0, 3'd0, 4};
        tbl[11] = '{5'b01001, 32'h204, 32'h0, 32'h89ABCDEF, 2, 2, -1, 1, 1, 0, 32'h89ABCDEF, 2, 4'hF, 32'h0, 3'd0, 5};
        tbl[12] = '{5'b00001, 32'h102, 32'h0, 32'h0, 0, 1, -1, 0, 0, 1, 32'h0, 0, 4'h0, 32'h0, 3'd0, 0};
        tbl[13] = '{5'b11011, 32'h77, 32'h0, 32'h0, 0, 1, 0, 0, 1, 1, 32'h0, 3, 4'h0, 32'h0, 3'd4, 9};
        tbl[14] = '{5'b11001, 32'h10, 32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 32'h0, 3, 4'h0, 32'h0, 3'd3, 2};
        tbl[15] = '{5'b10000, 32'h20, 32'h0, 32'h0, 0, 1, 3, 2, 0, 0, 32'h0, 3, 4'h0, 32'h0, 3'd0, 4};
        tbl[16] = '{5'b01011, 32'h101, 32'h0, 32'h0000C300, 3, 1, -1, 0, 0, 0, 32'hC3, 2, 4'h2, 32'h0, 3'd0, 5};
        tbl[17] = '{5'b01001, 32'h201, 32'h0, 32'h0, 0, 1, -1, 0, 0, 1, 32'h0, 0, 4'h0, 32'h0, 3'd0, 0};
        tbl[18] = '{5'b11000, 32'h84, 32'h0, 32'h0, 0, 1, 9, 0, 0, 1, 32'h0, 3, 4'h0, 32'h0, 3'd2, 9};

        repeat (3) step();
        chk("reset_hold", 64'({cmd_ready, mem_req, pim_start, rsp_valid, rsp_err, mem_be}), 64'(9'b1_0000_0000));
        rst = 0;
        step();
        chk("reset_release", 64'({cmd_ready, mem_req, mem_we, pim_start, rsp_valid, rsp_err}), 64'(6'b100000));
        chk("reset_data", 64'({rsp_data, mem_wdata}), 64'(0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("t%0d", i));

        // reset while waiting for load data: no response, back to idle
        cmd_valid = 1; cmd_code = 5'b01001; cmd_addr = 32'h300;
        step();
        cmd_valid = 0;
        chk("rst_seq_req", 64'(mem_req), 64'(1));
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        chk("rst_seq_wait", 64'({mem_req, rsp_valid, cmd_ready}), 64'(0));
        rst = 1;
        step();
        rst = 0;
        chk("rst_seq_idle", 64'({cmd_ready, mem_req, pim_start, rsp_valid, mem_be}), 64'(8'b1000_0000));
        mem_rvalid = 1; mem_rdata = 32'h12345678; pim_done = 1;
        step();
        mem_rvalid = 0; pim_done = 0;
        step();
        chk("rst_seq_no_rsp", 64'({rsp_valid, rsp_data, cmd_ready}), 64'(1));
        apply(tbl[0], "after_rst");

        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v.code = pool[$urandom_range(0, 15)];
            v.addr = 32'h1000 + $urandom_range(0, 1023);
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.g = $urandom_range(0, 3);
            v.r = $urandom_range(1, 3);
            v.k = $urandom_range(0, 10);
            v.rdy = $urandom_range(0, 3);
            v.noise = 1'($urandom_range(0, 1));
            v = model(v);
            apply(v, $sformatf("r%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
